// File: rtl/cclut_lut_sched_pkg.sv
// Shared definitions for the CCLUT lookup scheduler.
//   - Field widths of the pattern id, comparator code and ROM word
//   - Scheduler FSM state encoding
//   - Read tags that travel alongside each ROM read in flight
//   - ROM word field positions and slicing helpers
// The DIAG state exists only when CCLUT_DIAG_PORT_EN is defined.
package cclut_lut_sched_pkg;

    localparam int unsigned MXPIDB  = 4;   // pattern-id width
    localparam int unsigned MXPATC  = 12;  // comparator code width = ROM address width
    localparam int unsigned MXDATB  = 9;   // ROM word width
    localparam int unsigned MXOFFSB = 4;   // offset field width
    localparam int unsigned MXBNDB  = 5;   // bend field width

    localparam int unsigned OFFS_LSB = 5;
    localparam int unsigned BND_LSB  = 0;

`ifdef CCLUT_DIAG_PORT_EN
    typedef enum logic [1:0] {StIdle, StIssue0, StIssue1, StDiag} state_e;
`else
    typedef enum logic [1:0] {StIdle, StIssue0, StIssue1} state_e;
`endif

    typedef enum logic [1:0] {TAG_NONE, TAG_C0, TAG_C1, TAG_DG} tag_e;

    // blank marks a read whose pid has no ROM; its returned word is forced to 0
    typedef struct packed {
        tag_e tag;
        logic blank;
    } tag_ent_t;

    function automatic logic [MXOFFSB-1:0] word_offs(input logic [MXDATB-1:0] w);
        return w[OFFS_LSB +: MXOFFSB];
    endfunction

    function automatic logic [MXBNDB-1:0] word_bend(input logic [MXDATB-1:0] w);
        return w[BND_LSB +: MXBNDB];
    endfunction

endpackage

// File: rtl/cclut_lut_sched_if.sv
// Bus bundle of the CCLUT lookup scheduler.
//   Trigger side : trig_vld, pid00/pid01, carry00/carry01
//   ROM port     : lut_en, lut_pid, lut_adr (out), lut_rd (in)
//   Results      : out_vld, offs0/offs1, bend0/bend1, trig_ovf, ovf_cnt
//   Diagnostics  : diag_req, diag_pid, diag_adr (in), diag_ack, diag_data (out)
// master = the scheduler, slave = its environment (pattern finder, ROMs, slow control).
interface cclut_lut_sched_if;
    import cclut_lut_sched_pkg::*;

    logic              trig_vld;
    logic [MXPIDB-1:0] pid00;
    logic [MXPIDB-1:0] pid01;
    logic [MXPATC-1:0] carry00;
    logic [MXPATC-1:0] carry01;

    logic              lut_en;
    logic [MXPIDB-1:0] lut_pid;
    logic [MXPATC-1:0] lut_adr;
    logic [MXDATB-1:0] lut_rd;

    logic               out_vld;
    logic [MXOFFSB-1:0] offs0;
    logic [MXOFFSB-1:0] offs1;
    logic [MXBNDB-1:0]  bend0;
    logic [MXBNDB-1:0]  bend1;

    logic              diag_req;
    logic [MXPIDB-1:0] diag_pid;
    logic [MXPATC-1:0] diag_adr;
    logic              diag_ack;
    logic [MXDATB-1:0] diag_data;

    logic       trig_ovf;
    logic [7:0] ovf_cnt;

    modport master (
        input  trig_vld, pid00, pid01, carry00, carry01,
        output lut_en, lut_pid, lut_adr,
        input  lut_rd,
        output out_vld, offs0, offs1, bend0, bend1,
        input  diag_req, diag_pid, diag_adr,
        output diag_ack, diag_data,
        output trig_ovf, ovf_cnt
    );

    modport slave (
        output trig_vld, pid00, pid01, carry00, carry01,
        input  lut_en, lut_pid, lut_adr,
        output lut_rd,
        input  out_vld, offs0, offs1, bend0, bend1,
        output diag_req, diag_pid, diag_adr,
        input  diag_ack, diag_data,
        input  trig_ovf, ovf_cnt
    );

endinterface

// File: rtl/cclut_lut_sched_tag_pipe.sv
// cclut_tag_pipe: delay line carrying the tag of each ROM read in flight.
//   clock   : system clock
//   reset   : synchronous active-high, flushes every stage to TAG_NONE
//   tag_in  : tag of the read issued this clock (TAG_NONE when idle)
//   tag_out : tag_in delayed by DEPTH clocks
// Stage 0 is loaded on the same edge that launches lut_en, so stage k lines up
// with the k-th clock after the issue cycle.
module cclut_tag_pipe
    import cclut_lut_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clock,
    input  logic     reset,
    input  tag_ent_t tag_in,
    output tag_ent_t tag_out
);

    tag_ent_t stage_q [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '{tag: TAG_NONE, blank: 1'b0};
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/cclut_lut_sched.sv
// cclut_lut_sched: shares one CCLUT ROM read port between the two per-BX CLCT
// lookups and a slow-control diagnostic readback.
//   clock, reset : system clock, synchronous active-high reset
//   bus (master) : trigger capture, ROM port, offset/bend results, diag port,
//                  overflow flag and saturating drop counter
// Parameters: RD_LAT = ROM read latency (1..3), NPID = number of valid pids.
// Trigger latency is trig_vld at T -> out_vld at T+3+RD_LAT. Trigger reads have
// strict priority; diag reads only use idle slots, one outstanding at a time.
// Build option: define CCLUT_DIAG_PORT_EN to include the diagnostic readback;
// without it diag_req is ignored and diag_ack/diag_data are tied to 0.
module cclut_lut_sched
    import cclut_lut_sched_pkg::*;
#(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned NPID   = 5
) (
    input logic               clock,
    input logic               reset,
    cclut_lut_sched_if.master bus
);

    state_e            state_q, state_d;
    tag_e              issue_tag;
    logic [MXPIDB-1:0] issue_pid;
    logic [MXPATC-1:0] issue_adr;
    logic              trig_take;
    logic              trig_drop;

    logic              lut_en_q;
    logic [MXPIDB-1:0] lut_pid_q;
    logic [MXPATC-1:0] lut_adr_q;
    logic [MXPIDB-1:0] pid01_q;
    logic [MXPATC-1:0] carry01_q;
    logic              trig_ovf_q;
    logic [7:0]        ovf_cnt_q;

`ifdef CCLUT_DIAG_PORT_EN
    logic              diag_busy_q;
    logic              diag_ack_q;
    logic [MXDATB-1:0] diag_data_q;
`endif

    // ---------------------------------------------------------------
    // Issue decision
    // ---------------------------------------------------------------
    always_comb begin
        state_d   = StIdle;
        issue_tag = TAG_NONE;
        issue_pid = '0;
        issue_adr = '0;
        trig_take = 1'b0;
        trig_drop = 1'b0;
        unique case (state_q)
            StIssue0: begin
                // clct1 slot is committed; a trigger arriving now cannot be taken
                state_d   = StIssue1;
                issue_tag = TAG_C1;
                issue_pid = pid01_q;
                issue_adr = carry01_q;
                trig_drop = bus.trig_vld;
            end
            default: begin
                // Idle, Issue1 and Diag all accept a trigger, else a pending diag
                if (bus.trig_vld) begin
                    state_d   = StIssue0;
                    issue_tag = TAG_C0;
                    issue_pid = bus.pid00;
                    issue_adr = bus.carry00;
                    trig_take = 1'b1;
                end
`ifdef CCLUT_DIAG_PORT_EN
                else if (bus.diag_req && !diag_busy_q) begin
                    state_d   = StDiag;
                    issue_tag = TAG_DG;
                    issue_pid = bus.diag_pid;
                    issue_adr = bus.diag_adr;
                end
`endif
            end
        endcase
    end

    // ---------------------------------------------------------------
    // FSM with registered ROM-port and overflow outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            lut_en_q   <= 1'b0;
            lut_pid_q  <= '0;
            lut_adr_q  <= '0;
            pid01_q    <= '0;
            carry01_q  <= '0;
            trig_ovf_q <= 1'b0;
            ovf_cnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            lut_en_q <= (issue_tag != TAG_NONE);
            if (issue_tag != TAG_NONE) begin
                lut_pid_q <= issue_pid;
                lut_adr_q <= issue_adr;
            end
            if (trig_take) begin
                pid01_q   <= bus.pid01;
                carry01_q <= bus.carry01;
            end
            if (trig_drop) begin
                trig_ovf_q <= 1'b1;
                if (ovf_cnt_q != 8'hFF) begin
                    ovf_cnt_q <= ovf_cnt_q + 8'd1;
                end
            end
        end
    end

    assign bus.lut_en   = lut_en_q;
    assign bus.lut_pid  = lut_pid_q;
    assign bus.lut_adr  = lut_adr_q;
    assign bus.trig_ovf = trig_ovf_q;
    assign bus.ovf_cnt  = ovf_cnt_q;

    // ---------------------------------------------------------------
    // Tag pipe: tail lines up with the cycle lut_rd is valid
    // ---------------------------------------------------------------
    tag_ent_t push_ent;
    tag_ent_t tail_ent;

    assign push_ent = '{tag: issue_tag, blank: (32'(issue_pid) >= NPID)};

    cclut_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_tag_pipe (
        .clock   (clock),
        .reset   (reset),
        .tag_in  (push_ent),
        .tag_out (tail_ent)
    );

    logic [MXDATB-1:0] rd_word;
    assign rd_word = tail_ent.blank ? '0 : bus.lut_rd;

    // ---------------------------------------------------------------
    // Result reassembly: clct0 word parked until clct1 returns
    // ---------------------------------------------------------------
    logic [MXDATB-1:0]  word0_q;
    logic               out_vld_q;
    logic [MXOFFSB-1:0] offs0_q, offs1_q;
    logic [MXBNDB-1:0]  bend0_q, bend1_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            word0_q   <= '0;
            out_vld_q <= 1'b0;
            offs0_q   <= '0;
            offs1_q   <= '0;
            bend0_q   <= '0;
            bend1_q   <= '0;
        end else begin
            out_vld_q <= 1'b0;
            unique case (tail_ent.tag)
                TAG_C0: word0_q <= rd_word;
                TAG_C1: begin
                    out_vld_q <= 1'b1;
                    offs0_q   <= word_offs(word0_q);
                    bend0_q   <= word_bend(word0_q);
                    offs1_q   <= word_offs(rd_word);
                    bend1_q   <= word_bend(rd_word);
                end
                default: ;
            endcase
        end
    end

    assign bus.out_vld = out_vld_q;
    assign bus.offs0   = offs0_q;
    assign bus.offs1   = offs1_q;
    assign bus.bend0   = bend0_q;
    assign bus.bend1   = bend1_q;

    // ---------------------------------------------------------------
    // Diagnostic completion
    // ---------------------------------------------------------------
`ifdef CCLUT_DIAG_PORT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            diag_busy_q <= 1'b0;
            diag_ack_q  <= 1'b0;
            diag_data_q <= '0;
        end else begin
            // busy drops after the ack cycle so a still-held req is not reissued
            if (issue_tag == TAG_DG) begin
                diag_busy_q <= 1'b1;
            end else if (diag_ack_q) begin
                diag_busy_q <= 1'b0;
            end
            diag_ack_q  <= (tail_ent.tag == TAG_DG);
            diag_data_q <= (tail_ent.tag == TAG_DG) ? rd_word : '0;
        end
    end

    assign bus.diag_ack  = diag_ack_q;
    assign bus.diag_data = diag_data_q;
`else
    logic unused_diag;
    assign unused_diag   = ^{bus.diag_req, bus.diag_pid, bus.diag_adr};
    assign bus.diag_ack  = 1'b0;
    assign bus.diag_data = '0;
`endif

endmodule

// File: doc/cclut_lut_sched.md
Name: cclut_lut_sched

Overview:
- Sequences one shared CCLUT ROM read port (one ROM per pid, address = comparator-code carry) between the two per-BX CLCT lookups (clct0, clct1) and a slow-control diagnostic readback.
- Sits between the pattern finder's best-two-CLCT selection and the CCLUT ROMs, replacing the dual-ported lookup.
- Time-multiplexes the lookups, tags each read in flight, and reassembles offset/bend pairs with fixed latency.
- Trigger traffic has strict priority; diagnostic reads fill idle slots.

Parameters:
- MXPIDB, 4, pattern-id width
- MXPATC, 12, comparator-code (carry) width = ROM address width
- MXDATB, 9, ROM word width ([8:5] offset, [4:0] bend)
- MXOFFSB, 4, offset width
- MXBNDB, 5, bend width
- RD_LAT, 1, ROM read latency in clocks (1..3)
- NPID, 5, valid pids are 0..NPID-1

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- trig_vld  in  1  one-cycle strobe: new CLCT pair
- pid00, pid01  in  MXPIDB  pattern ids of clct0/clct1
- carry00, carry01  in  MXPATC  comparator codes of clct0/clct1
- lut_en  out  1  ROM read strobe
- lut_pid  out  MXPIDB  ROM select
- lut_adr  out  MXPATC  ROM address
- lut_rd  in  MXDATB  ROM data, valid RD_LAT clocks after lut_en
- out_vld  out  1  result strobe
- offs0, offs1  out  MXOFFSB  offsets
- bend0, bend1  out  MXBNDB  bends
- diag_req  in  1  level; held until diag_ack
- diag_pid  in  MXPIDB  diag ROM select
- diag_adr  in  MXPATC  diag ROM address
- diag_ack  out  1  one-cycle done strobe
- diag_data  out  MXDATB  diag ROM word
- trig_ovf  out  1  sticky: trigger dropped
- ovf_cnt  out  8  saturating dropped-trigger count

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; tag pipe flushed. Reset mid-operation discards in-flight reads; no out_vld or diag_ack may follow until new requests arrive.
- States: IDLE, ISSUE0, ISSUE1, DIAG.
- Trigger capture: trig_vld is accepted in IDLE, ISSUE1 or DIAG.
  - pid/carry are registered.
  - Next state is ISSUE0 (issue clct0), then ISSUE1 (issue clct1).
  - trig_vld seen in ISSUE0 is dropped: trig_ovf set, ovf_cnt incremented (saturates at 255). Minimum trigger spacing is therefore 2 clocks.
- ISSUE1 next state:
  - trig_vld → ISSUE0
  - else diag_req and no diag outstanding → DIAG
  - else IDLE
- IDLE next state: trig_vld → ISSUE0; else diag_req and no diag outstanding → DIAG.
- Same-cycle trig_vld and diag_req: trigger wins; diag waits.
- DIAG: one issue cycle with lut_pid/adr = diag_pid/diag_adr; next state follows the IDLE rules.
- Issue cycle outputs: lut_en=1 and lut_pid/lut_adr are registered outputs. A tag (C0, C1, DG) enters a shift pipe of depth RD_LAT+1.
- Pid outside 0..NPID-1: lut_en is still pulsed, but the returned word is forced to 0 (blank pattern).
- Result capture: lut_rd is captured at tag C0/C1.
  - out_vld pulses in the cycle after the C1 data arrives, with both pairs.
  - offs = word[8:5], bend = word[4:0].
- Latency: trig_vld at cycle T → issue C0 at T+1, C1 at T+2 → out_vld at T+3+RD_LAT (T+4 at default).
- Outputs hold their value between out_vld pulses.
- Diag completion: diag_ack and diag_data are asserted RD_LAT+1 clocks after the DG issue, for one cycle. Only one diag read is outstanding at a time.
- diag_req deasserted before ack: the read still completes and the ack is still pulsed.
- Back-to-back triggers every 2 clocks sustain one out_vld per 2 clocks with no drops; diag is starved during this.

Optional Feature:
- Macro: CCLUT_DIAG_PORT_EN.
- Defined: diagnostic readback as specified.
- Undefined: the DIAG state and DG tag are removed; diag_req is ignored; diag_ack and diag_data are tied to 0. Trigger behaviour and latency are unchanged.

Decomposition:
- Shared package:
  - widths MXPIDB, MXPATC, MXDATB, MXOFFSB, MXBNDB
  - FSM state encoding
  - tag enum {TAG_NONE, TAG_C0, TAG_C1, TAG_DG}
  - word field positions OFFS_LSB=5, BND_LSB=0
- One sub-module, cclut_tag_pipe: parameterized RD_LAT+1 delay line of tags with synchronous flush on reset.

Test Plan:
- Single trigger: pid00=4, carry00=0x0A5, pid01=2, carry01=0x3FF; ROM model returns 9'h1A3 then 9'h0C7 → lut_en at T+1/T+2 with those addresses. At T+4: out_vld=1, offs0=4'hD, bend0=5'h03, offs1=4'h6, bend1=5'h07.
- Triggers at T and T+1 → second dropped; trig_ovf=1, ovf_cnt=1, exactly one out_vld. Triggers at T, T+2, T+4 → three out_vld at T+4, T+6, T+8, no overflow.
- Invalid pid: pid00=7 → offs0=0, bend0=0; clct1 result is unaffected.
- Diag: diag_req with pid=1, adr=0x123 while idle → lut_en at next cycle, diag_ack 2 clocks later with the ROM word. diag_req asserted in the same cycle as trig_vld → trigger issued first, diag issued in the slot after ISSUE1.
- Reset asserted one cycle after trig_vld → no out_vld; all outputs 0; ovf_cnt=0.
- Overflow saturation: 300 drops → ovf_cnt=255, trig_ovf remains 1.
